fpro_bus_arbiter: RTL

Two-master arbiter that shares the single FPro MMIO bus (`cs`/`rd`/`wr`/21-bit address/32-bit data) between the MicroBlaze bridge side (master 0) and a secondary bus master such as a DMA or debug UART engine (master 1). It sits between the masters and the MMIO wrapper. Each access runs as one fully registered single-cycle bus strobe, so the MMIO slots see exactly the timing they see today. Arbitration is round-robin, with fixed priority available as a compile-time option.

---
 rtl/fpro_arb_pkg.sv | 18 +
 rtl/fpro_arb_picker.sv | 30 +++
 rtl/fpro_bus_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fpro_arb_pkg.sv
// Shared types and default widths for the two-master FPro MMIO bus arbiter.
package fpro_arb_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 21;
  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

  typedef logic arb_idx_t;

  localparam arb_idx_t IDX_M0 = 1'b0;
  localparam arb_idx_t IDX_M1 = 1'b1;

endpackage

// File: rtl/fpro_arb_picker.sv
// Combinational winner select for the bus arbiter. Round-robin by default;
// FPRO_ARB_FIXED_PRIO_EN makes master 0 win every contention.
module fpro_arb_picker
  import fpro_arb_pkg::*;
(
  input  logic     i_req0,
  input  logic     i_req1,
  input  arb_idx_t i_last,
  output logic     o_valid,
  output arb_idx_t o_winner
);

  always_comb begin
    o_valid  = i_req0 | i_req1;
    o_winner = IDX_M0;
`ifdef FPRO_ARB_FIXED_PRIO_EN
    if (!i_req0 && i_req1) o_winner = IDX_M1;
`else
    // On contention the master that did not win last time goes first.
    if (i_req0 && i_req1) o_winner = (i_last == IDX_M0) ? IDX_M1 : IDX_M0;
    else if (i_req1)      o_winner = IDX_M1;
`endif
  end

`ifdef FPRO_ARB_FIXED_PRIO_EN
  logic w_unused_last;
  assign w_unused_last = i_last;
`endif

endmodule

// File: rtl/fpro_bus_arbiter.sv
// Two-master arbiter in front of the FPro MMIO bus: one registered single-cycle
// strobe per access (IDLE -> ISSUE -> DONE). FPRO_ARB_FIXED_PRIO_EN selects fixed priority.
module fpro_bus_arbiter
  import fpro_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_wr,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wr_data,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rd_data,
  input  logic                  m1_req,
  input  logic                  m1_wr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wr_data,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rd_data,
  output logic                  fp_mmio_cs,
  output logic                  fp_rd,
  output logic                  fp_wr,
  output logic [ADDR_WIDTH-1:0] fp_addr,
  output logic [DATA_WIDTH-1:0] fp_wr_data,
  input  logic [DATA_WIDTH-1:0] fp_rd_data,
  output arb_state_t            o_dbg_state
);

  arb_state_t            r_state;
  arb_idx_t              r_winner;
  arb_idx_t              r_last;
  logic                  r_cs;
  logic                  r_rd;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_ack0;
  logic                  r_ack1;
  logic [DATA_WIDTH-1:0] r_rd_data0;
  logic [DATA_WIDTH-1:0] r_rd_data1;

  logic                  w_grant_valid;
  arb_idx_t              w_winner;
  logic                  w_sel_wr;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wr_data;

  // In the fixed-priority build the picker ignores r_last, so the pointer is pruned.
  fpro_arb_picker u_picker (
    .i_req0   (m0_req),
    .i_req1   (m1_req),
    .i_last   (r_last),
    .o_valid  (w_grant_valid),
    .o_winner (w_winner)
  );

  assign w_sel_wr      = (w_winner == IDX_M1) ? m1_wr      : m0_wr;
  assign w_sel_addr    = (w_winner == IDX_M1) ? m1_addr    : m0_addr;
  assign w_sel_wr_data = (w_winner == IDX_M1) ? m1_wr_data : m0_wr_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_winner   <= IDX_M0;
      r_last     <= IDX_M1;
      r_cs       <= 1'b0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_wr_data  <= '0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_rd_data0 <= '0;
      r_rd_data1 <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ack0 <= 1'b0;
          r_ack1 <= 1'b0;
          if (w_grant_valid) begin
            r_winner  <= w_winner;
            r_cs      <= 1'b1;
            r_rd      <= !w_sel_wr;
            r_wr      <= w_sel_wr;
            r_addr    <= w_sel_addr;
            r_wr_data <= w_sel_wr_data;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          // Slot read data is combinational in the strobe cycle; capture it here.
          r_cs <= 1'b0;
          r_rd <= 1'b0;
          r_wr <= 1'b0;
          if (r_rd) begin
            if (r_winner == IDX_M1) r_rd_data1 <= fp_rd_data;
            else                    r_rd_data0 <= fp_rd_data;
          end
          r_ack0  <= (r_winner == IDX_M0);
          r_ack1  <= (r_winner == IDX_M1);
          r_state <= DONE;
        end
        DONE: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_last  <= r_winner;
          r_state <= IDLE;
        end
        default: begin
          r_cs    <= 1'b0;
          r_rd    <= 1'b0;
          r_wr    <= 1'b0;
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign fp_mmio_cs  = r_cs;
  assign fp_rd       = r_rd;
  assign fp_wr       = r_wr;
  assign fp_addr     = r_addr;
  assign fp_wr_data  = r_wr_data;
  assign m0_ack      = r_ack0;
  assign m1_ack      = r_ack1;
  assign m0_rd_data  = r_rd_data0;
  assign m1_rd_data  = r_rd_data1;
  assign o_dbg_state = r_state;

endmodule
